// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared constants for forwarding/hazard control
// Contents: forwarding-mux select codes, default register-index width and the
// pipeline slot field layout {valid, rd, reg_write, mem_read}.
package fwd_hazard_unit_pkg;

    localparam int REG_W_DEF = 5;

    // Select codes for the EX-stage 3-input operand muxes; 2'd3 is never driven.
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Slot field layout, LSB first: mem_read, reg_write, rd[REG_W-1:0], valid.
    localparam int SLOT_MR_BIT = 0;
    localparam int SLOT_RW_BIT = 1;
    localparam int SLOT_RD_LSB = 2;

    function automatic int slot_width(input int reg_w);
        return reg_w + 3;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_cmp.sv
// rtl/fwd_hazard_unit_src_cmp.sv - one source operand against the EX and MEM slots
// Ports: src/use_src = ID source index and its live-use flag (already gated by id_valid);
//        ex_* / mem_* = slot fields; sel = next-cycle forwarding select;
//        load_hit = this source needs the ID instruction held this cycle.
module fwd_src_cmp
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int ZERO_REG = 0,
    parameter bit FWD_EN   = 1'b1
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             mem_valid,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    output logic [1:0]       sel,
    output logic             load_hit
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    logic live;
    logic ex_hit;
    logic mem_hit;

    assign live    = use_src && (src != ZERO_IDX);
    assign ex_hit  = live && ex_valid  && ex_reg_write  && (ex_rd  == src);
    assign mem_hit = live && mem_valid && mem_reg_write && (mem_rd == src);

    always_comb begin
        sel      = FWD_RF;
        load_hit = 1'b0;
        if (FWD_EN) begin
            // The EX slot is the youngest producer, so it wins over MEM.
            if (ex_hit) begin
                sel = FWD_EXMEM;
            end else if (mem_hit) begin
                sel = FWD_MEMWB;
            end
            // A load's data only exists after MEM, so an EX-slot load cannot feed us yet.
            load_hit = ex_hit && ex_mem_read;
        end else begin
            // Without forwarding every in-flight producer must drain to the register file.
            load_hit = ex_hit || mem_hit;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding selects and load-use stall/bubble for a 5-stage pipeline
// Ports: clk/rst (sync, active-high); id_* = decoded ID instruction; flush = taken
//        branch/jump in EX; stall/bubble = combinational pipeline-register controls;
//        fwd_a_sel/fwd_b_sel = registered operand selects for the instruction now in EX.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int ZERO_REG = 0,
    parameter bit FWD_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel
);

    localparam int SW = slot_width(REG_W);

    // The WB slot is not stored: the register file writes in the first half-cycle,
    // so a WB producer is already visible to the ID read and never forwarded or
    // stalled on. The MEM slot likewise drops mem_read, which nothing downstream reads.
    logic [SW-1:0]    ex_q, ex_d;
    logic             mem_valid_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             mem_rw_q;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;

    logic             ex_valid;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rw;
    logic             ex_mr;

    logic [1:0]       sel_a, sel_b;
    logic             load_a, load_b;

    assign ex_valid = ex_q[SW-1];
    assign ex_rd    = ex_q[SLOT_RD_LSB +: REG_W];
    assign ex_rw    = ex_q[SLOT_RW_BIT];
    assign ex_mr    = ex_q[SLOT_MR_BIT];

    fwd_src_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG), .FWD_EN(FWD_EN)) u_cmp_rs (
        .src           (id_rs),
        .use_src       (id_valid && id_uses_rs),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_rw),
        .ex_mem_read   (ex_mr),
        .mem_valid     (mem_valid_q),
        .mem_rd        (mem_rd_q),
        .mem_reg_write (mem_rw_q),
        .sel           (sel_a),
        .load_hit      (load_a)
    );

    fwd_src_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG), .FWD_EN(FWD_EN)) u_cmp_rt (
        .src           (id_rt),
        .use_src       (id_valid && id_uses_rt),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_rw),
        .ex_mem_read   (ex_mr),
        .mem_valid     (mem_valid_q),
        .mem_rd        (mem_rd_q),
        .mem_reg_write (mem_rw_q),
        .sel           (sel_b),
        .load_hit      (load_b)
    );

    // A flush kills the ID instruction anyway, so holding it would only delay the redirect.
    assign stall  = !rst && !flush && (load_a || load_b);
    assign bubble = !rst && (stall || flush);

    always_comb begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (id_valid && !stall && !flush) begin
            ex_d[SW-1]                  = 1'b1;
            ex_d[SLOT_RD_LSB +: REG_W]  = id_rd;
            ex_d[SLOT_RW_BIT]           = id_reg_write;
            ex_d[SLOT_MR_BIT]           = id_mem_read;
        end
        // The bubble entering EX reads nothing, so it gets register-file selects.
        if (!stall && !flush) begin
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
        end else begin
            ex_q        <= ex_d;
            mem_valid_q <= ex_valid;
            mem_rd_q    <= ex_rd;
            mem_rw_q    <= ex_rw;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit, forwarding on and off
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rs = 1'b0;
    logic       id_uses_rt = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       flush = 1'b0;

    logic       stall_f, bubble_f;
    logic [1:0] a_f, b_f;
    logic       stall_n, bubble_n;
    logic [1:0] a_n, b_n;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_W(5), .ZERO_REG(0), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .stall(stall_f), .bubble(bubble_f), .fwd_a_sel(a_f), .fwd_b_sel(b_f)
    );

    fwd_hazard_unit #(.REG_W(5), .ZERO_REG(0), .FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .stall(stall_n), .bubble(bubble_n), .fwd_a_sel(a_n), .fwd_b_sel(b_n)
    );

    // Reference model: per configuration (0 = forwarding, 1 = no forwarding), the
    // instructions accepted into EX, youngest first: age 0 in EX, age 1 in MEM.
    typedef struct { bit v; int rd; bit rw; bit mr; } ent_t;
    ent_t pipe [2][2];

    typedef struct packed { logic s0; logic bb0; logic s1; logic bb1; } comb_t;
    typedef struct packed { logic [1:0] a0; logic [1:0] b0; logic [1:0] a1; logic [1:0] b1; } sel_t;
    comb_t q_comb[$];
    sel_t  q_sel[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Age of the youngest in-flight writer of idx, or -1 when none.
    function automatic int hit_age(input int c, input bit live, input int idx);
        if (!live || idx == 0) return -1;
        for (int k = 0; k < 2; k++)
            if (pipe[c][k].v && pipe[c][k].rw && pipe[c][k].rd == idx) return k;
        return -1;
    endfunction

    task automatic issue(input bit r, input bit v, input int rs, input int rt,
                         input bit urs, input bit urt, input int rd, input bit rw,
                         input bit mr, input bit fl);
        comb_t ce;
        sel_t  se;
        @(negedge clk);
        rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_rd = 5'(rd);
        id_reg_write = rw; id_mem_read = mr; flush = fl;
        for (int c = 0; c < 2; c++) begin
            int ha, hb, sa, sb;
            bit fe, req, st, bu;
            fe  = (c == 0);
            ha  = hit_age(c, v && urs, rs);
            hb  = hit_age(c, v && urt, rt);
            // With forwarding only a load still in EX blocks; otherwise any producer does.
            req = fe ? ((ha == 0 || hb == 0) && pipe[c][0].mr) : (ha >= 0 || hb >= 0);
            st  = !r && !fl && req;
            bu  = !r && (st || fl);
            sa  = (r || st || fl || !fe || ha < 0) ? 0 : ha + 1;
            sb  = (r || st || fl || !fe || hb < 0) ? 0 : hb + 1;
            if (c == 0) begin
                ce.s0 = st; ce.bb0 = bu; se.a0 = 2'(sa); se.b0 = 2'(sb);
            end else begin
                ce.s1 = st; ce.bb1 = bu; se.a1 = 2'(sa); se.b1 = 2'(sb);
            end
            if (r) begin
                pipe[c][0] = '{0, 0, 0, 0};
                pipe[c][1] = '{0, 0, 0, 0};
            end else begin
                pipe[c][1] = pipe[c][0];
                if (v && !st && !fl) pipe[c][0] = '{1, rd, rw, mr};
                else                 pipe[c][0] = '{0, 0, 0, 0};
            end
        end
        q_comb.push_back(ce);
        q_sel.push_back(se);
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Combinational outputs: checked mid-cycle, after the inputs for that cycle settle.
    initial begin
        comb_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q_comb.size() > 0) begin
                e = q_comb.pop_front();
                chk("stall_fwd",    4'(stall_f),  4'(e.s0));
                chk("bubble_fwd",   4'(bubble_f), 4'(e.bb0));
                chk("stall_nofwd",  4'(stall_n),  4'(e.s1));
                chk("bubble_nofwd", 4'(bubble_n), 4'(e.bb1));
            end
        end
    end

    // Registered selects: checked just after the edge that loaded them.
    initial begin
        sel_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_sel.size() > 0) begin
                e = q_sel.pop_front();
                chk("fwd_a_sel_fwd",   4'(a_f), 4'(e.a0));
                chk("fwd_b_sel_fwd",   4'(b_f), 4'(e.b0));
                chk("fwd_a_sel_nofwd", 4'(a_n), 4'(e.a1));
                chk("fwd_b_sel_nofwd", 4'(b_n), 4'(e.b1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 2; k++) pipe[c][k] = '{0, 0, 0, 0};

        // Reset held with a valid reader in ID.
        issue(1, 1, 3, 0, 1, 0, 0, 0, 0, 0);
        issue(1, 1, 3, 0, 1, 0, 0, 0, 0, 0);

        // Back-to-back ALU, then a reader one instruction later.
        issue(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
        issue(0, 1, 5, 2, 1, 1, 6, 1, 0, 0);
        issue(0, 1, 1, 2, 1, 1, 6, 1, 0, 0);
        issue(0, 1, 5, 0, 1, 0, 8, 1, 0, 0);
        nop(); nop();

        // Load-use with rs == rt, retried until accepted.
        issue(0, 1, 1, 0, 1, 0, 7, 1, 1, 0);
        issue(0, 1, 7, 7, 1, 1, 9, 1, 0, 0);
        issue(0, 1, 7, 7, 1, 1, 9, 1, 0, 0);
        issue(0, 1, 7, 7, 1, 1, 9, 1, 0, 0);
        nop(); nop();

        // Zero register is never a forwarding source.
        issue(0, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        issue(0, 1, 0, 0, 1, 1, 3, 1, 0, 0);
        nop(); nop();

        // Flush on top of a load-use hazard, then a reader of the load.
        issue(0, 1, 1, 0, 1, 0, 4, 1, 1, 0);
        issue(0, 1, 4, 0, 1, 0, 6, 1, 0, 1);
        issue(0, 1, 4, 0, 1, 0, 2, 1, 0, 0);
        nop(); nop();

        // Distinct slots per source: A from EX, B from MEM.
        issue(0, 1, 0, 0, 0, 0, 10, 1, 0, 0);
        issue(0, 1, 0, 0, 0, 0, 11, 1, 0, 0);
        issue(0, 1, 11, 10, 1, 1, 12, 1, 0, 0);
        nop(); nop();

        // Producer in MEM only, and a reset in the middle of a load-use stall.
        issue(0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        nop();
        issue(0, 1, 9, 0, 1, 0, 3, 1, 0, 0);
        issue(0, 1, 0, 0, 0, 0, 13, 1, 1, 0);
        issue(0, 1, 13, 0, 1, 0, 3, 1, 0, 0);
        issue(1, 1, 13, 0, 1, 0, 3, 1, 0, 0);
        issue(0, 1, 13, 0, 1, 0, 3, 1, 0, 0);
        nop(); nop();

        // Randomised traffic over a small register range so hazards are frequent.
        for (int i = 0; i < 800; i++) begin
            issue($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
        end
        nop(); nop();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 4'(q_comb.size() + q_sel.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
